register_file: RTL and testbench

- Integer register file for the single-cycle core; sits directly upstream of the ALU.
- Its rs1/rs2 read ports drive the ALU operand1/operand2 (operand2 through the immediate mux).
- Its write port takes the writeback value (ALU result, load data or PC+4) and commits it at the clock edge.
- Provides x0 hardwiring, a stack-pointer reset value, optional same-cycle write-to-read bypass, a debug read port and a committed-write counter.

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_if.sv | 28 ++
 rtl/register_file_read_port.sv | 30 +++
 rtl/register_file.sv | 67 ++++++
 tb/tb_register_file.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/register_file_pkg.sv
// Shared core types: register addresses, XLEN words and
// architectural register constants used by the regfile, ALU and control.
package core_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xlen_t;

   localparam reg_addr_t REG_ZERO = 5'd0;
   localparam reg_addr_t REG_SP   = 5'd2;
endpackage

// File: rtl/register_file_if.sv
// Register file access bundle: two read ports, one write port,
// a debug read port and the committed-write counter.
interface register_file_if #(
   parameter int XLEN = 32
);
   import core_pkg::*;

   reg_addr_t        rs1_addr;
   reg_addr_t        rs2_addr;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             reg_write;
   reg_addr_t        rd_addr;
   logic [XLEN-1:0]  rd_data;
   reg_addr_t        dbg_addr;
   logic [XLEN-1:0]  dbg_data;
   logic [31:0]      wr_count;

   modport master (
      output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, dbg_addr,
      input  rs1_data, rs2_data, dbg_data, wr_count
   );

   modport slave (
      input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data, dbg_addr,
      output rs1_data, rs2_data, dbg_data, wr_count
   );
endinterface

// File: rtl/register_file_read_port.sv
// One register read port: x0 / out-of-range masking and optional
// same-cycle forwarding of the write-port data.
module regfile_read_port
   import core_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int BYPASS   = 1
) (
   input  reg_addr_t                       addr,
   input  logic [NUM_REGS-1:0][XLEN-1:0]   regs,
   input  logic                            wr_en,
   input  reg_addr_t                       wr_addr,
   input  logic [XLEN-1:0]                 wr_data,
   output logic [XLEN-1:0]                 data
);
   logic valid;
   logic hit;

   assign valid = (addr != REG_ZERO) && (int'(addr) < NUM_REGS);
   // wr_en is already qualified by reset, x0 and range
   assign hit   = (BYPASS != 0) && wr_en && (addr == wr_addr);

   always_comb begin
      data = '0;
      if (valid) begin
         data = hit ? wr_data : regs[addr];
      end
   end
endmodule

// File: rtl/register_file.sv
// Integer register file: x0 hardwired, sp reset value, two bypassable
// read ports, a plain debug read port and a committed-write counter.
module register_file
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NUM_REGS = 32,
   parameter logic [XLEN-1:0] SP_INIT  = 32'h0000_0FFC,
   parameter int              BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   register_file_if.slave        rf
);
   logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
   logic [31:0]                   cnt_q;
   logic                          wr_en;
   logic                          dbg_valid;

   assign wr_en = rst_n && rf.reg_write
                  && (rf.rd_addr != REG_ZERO)
                  && (int'(rf.rd_addr) < NUM_REGS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
         end
         cnt_q <= '0;
      end else if (wr_en) begin
         regs_q[rf.rd_addr] <= rf.rd_data;
         cnt_q              <= cnt_q + 32'd1;
      end
   end

   regfile_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS)
   ) u_rs1 (
      .addr    (rf.rs1_addr),
      .regs    (regs_q),
      .wr_en   (wr_en),
      .wr_addr (rf.rd_addr),
      .wr_data (rf.rd_data),
      .data    (rf.rs1_data)
   );

   regfile_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .BYPASS   (BYPASS)
   ) u_rs2 (
      .addr    (rf.rs2_addr),
      .regs    (regs_q),
      .wr_en   (wr_en),
      .wr_addr (rf.rd_addr),
      .wr_data (rf.rd_data),
      .data    (rf.rs2_data)
   );

   // debug view is never forwarded
   assign dbg_valid = (rf.dbg_addr != REG_ZERO)
                      && (int'(rf.dbg_addr) < NUM_REGS);
   assign rf.dbg_data = dbg_valid ? regs_q[rf.dbg_addr] : '0;
   assign rf.wr_count = cnt_q;
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: one bypassing and one
// non-bypassing instance driven in lockstep against a reference model.
module tb_register_file;
   import core_pkg::*;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   reg_addr_t   rs1_addr = '0;
   reg_addr_t   rs2_addr = '0;
   reg_addr_t   rd_addr = '0;
   reg_addr_t   dbg_addr = '0;
   logic        reg_write = 1'b0;
   logic [31:0] rd_data = '0;

   logic [31:0] mdl [32];
   logic [31:0] mcnt;
   sb_t         sbq [$];
   int          total = 0;
   int          bad = 0;

   register_file_if #(.XLEN(32)) rf_b ();
   register_file_if #(.XLEN(32)) rf_n ();

   assign rf_b.rs1_addr  = rs1_addr;
   assign rf_b.rs2_addr  = rs2_addr;
   assign rf_b.rd_addr   = rd_addr;
   assign rf_b.dbg_addr  = dbg_addr;
   assign rf_b.reg_write = reg_write;
   assign rf_b.rd_data   = rd_data;
   assign rf_n.rs1_addr  = rs1_addr;
   assign rf_n.rs2_addr  = rs2_addr;
   assign rf_n.rd_addr   = rd_addr;
   assign rf_n.dbg_addr  = dbg_addr;
   assign rf_n.reg_write = reg_write;
   assign rf_n.rd_data   = rd_data;

   register_file #(.BYPASS(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rf_b)
   );

   register_file #(.BYPASS(0)) dut_n (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rf_n)
   );

   always #5 clk = ~clk;

   always @(negedge rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mdl[2] = 32'h0000_0FFC;
      mcnt = '0;
   end

   always @(posedge clk) begin
      if (rst_n && reg_write && rd_addr != 5'd0) begin
         mdl[rd_addr] = rd_data;
         mcnt = mcnt + 32'd1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input reg_addr_t a,
                                          input bit byp);
      if (a == 5'd0) return '0;
      if (byp && rst_n && reg_write && rd_addr == a) return rd_data;
      return mdl[a];
   endfunction

   task automatic push_all(input string tag);
      sbq.push_back('{ {tag, ".b.rs1"}, 0, exp_rd(rs1_addr, 1'b1) });
      sbq.push_back('{ {tag, ".b.rs2"}, 1, exp_rd(rs2_addr, 1'b1) });
      sbq.push_back('{ {tag, ".n.rs1"}, 2, exp_rd(rs1_addr, 1'b0) });
      sbq.push_back('{ {tag, ".n.rs2"}, 3, exp_rd(rs2_addr, 1'b0) });
      sbq.push_back('{ {tag, ".dbg"},   4, exp_rd(dbg_addr, 1'b0) });
      sbq.push_back('{ {tag, ".b.cnt"}, 5, mcnt });
      sbq.push_back('{ {tag, ".n.cnt"}, 6, mcnt });
   endtask

   task automatic drain();
      sb_t         e;
      logic [31:0] got;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.sel)
            0:       got = rf_b.rs1_data;
            1:       got = rf_b.rs2_data;
            2:       got = rf_n.rs1_data;
            3:       got = rf_n.rs2_data;
            4:       got = rf_b.dbg_data;
            5:       got = rf_b.wr_count;
            default: got = rf_n.wr_count;
         endcase
         check(e.tag, got, e.exp);
      end
   endtask

   task automatic sample(input string tag);
      #1;
      push_all(tag);
      drain();
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input reg_addr_t a, input logic [31:0] d);
      reg_write = 1'b1;
      rd_addr   = a;
      rd_data   = d;
      cyc();
      reg_write = 1'b0;
   endtask

   task automatic rd(input string tag, input reg_addr_t a1,
                     input reg_addr_t a2);
      rs1_addr = a1;
      rs2_addr = a2;
      dbg_addr = a1;
      sample(tag);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      rd("rst_sp", 5'd2, 5'd5);
      reg_write = 1'b1;
      rd_addr   = 5'd5;
      rd_data   = 32'h0000_0123;
      rs1_addr  = 5'd5;
      rs2_addr  = 5'd2;
      dbg_addr  = 5'd5;
      sample("rst_wr_pending");
      repeat (2) cyc();
      sample("rst_wr_ignored");
      reg_write = 1'b0;
      rst_n = 1'b1;

      cyc();
      wr(5'd5, 32'h3FFF_FFFF);
      wr(5'd6, 32'h3FFF_FFFF);
      rd("wr_back", 5'd5, 5'd6);
      check("wr_back.cnt2", rf_b.wr_count, 32'd2);

      reg_write = 1'b1;
      rd_addr   = 5'd0;
      rd_data   = 32'hDEAD_BEEF;
      rs1_addr  = 5'd0;
      rs2_addr  = 5'd0;
      dbg_addr  = 5'd0;
      sample("x0_same");
      cyc();
      reg_write = 1'b0;
      rd("x0_next", 5'd0, 5'd0);

      wr(5'd7, 32'h0000_0011);
      reg_write = 1'b1;
      rd_addr   = 5'd7;
      rd_data   = 32'h0000_0003;
      rs1_addr  = 5'd7;
      rs2_addr  = 5'd7;
      dbg_addr  = 5'd7;
      sample("byp_pre");
      @(posedge clk);
      #1 reg_write = 1'b0;
      sample("byp_post");
      @(negedge clk);
      rs2_addr = 5'd8;
      reg_write = 1'b1;
      rd_data = 32'h0000_0044;
      sample("byp_one_port");
      cyc();
      reg_write = 1'b0;

      for (int i = 0; i < 40; i++) begin
         reg_write = 1'($urandom_range(0, 1));
         rd_addr   = 5'($urandom_range(0, 9));
         rd_data   = $urandom;
         rs1_addr  = 5'($urandom_range(0, 9));
         rs2_addr  = (i % 4 == 0) ? rd_addr : 5'($urandom_range(0, 9));
         dbg_addr  = 5'($urandom_range(0, 31));
         sample("rand");
         cyc();
      end
      reg_write = 1'b0;

      wr(5'd9, 32'h0000_0055);
      reg_write = 1'b1;
      rd_addr   = 5'd9;
      rd_data   = 32'h0000_00AA;
      rs1_addr  = 5'd9;
      rs2_addr  = 5'd2;
      dbg_addr  = 5'd9;
      #2 rst_n = 1'b0;
      sample("rst_mid_now");
      check("rst_mid_now.x9", rf_b.rs1_data, 32'h0);
      @(posedge clk);
      sample("rst_mid_after");
      @(negedge clk);

      rd_addr = 5'd3;
      rd_data = 32'h0000_0077;
      rst_n   = 1'b1;
      cyc();
      reg_write = 1'b0;
      rd("rel_first", 5'd3, 5'd9);
      check("rel_first.cnt", rf_n.wr_count, 32'd1);

      force dut_b.cnt_q = 32'hFFFF_FFFE;
      force dut_n.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut_b.cnt_q;
      release dut_n.cnt_q;
      mcnt = 32'hFFFF_FFFE;
      wr(5'd4, 32'h0000_0001);
      rd("wrap1", 5'd4, 5'd0);
      wr(5'd4, 32'h0000_0002);
      rd("wrap2", 5'd4, 5'd0);
      check("wrap2.zero", rf_b.wr_count, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
